// File: rtl/switch_nport.sv
// switch_nport: parametrised N-port single-word packet switch.
//
// Each input presents one packet per handshake, tagged with a destination
// port index. Every output has a round-robin arbiter that picks one
// requester per cycle and writes {src, data} into that output's FIFO. The
// FIFO drains over a valid/ready stream.
//
// Optional feature macro: SWITCH_STATS_EN adds per-output delivered-packet
// counters on the stat_count port. These counters saturate at 16'hFFFF.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   reset      asynchronous active-low reset
//   in_valid   per-input packet valid
//   in_ready   per-input accept (combinational from in_valid/in_dest)
//   in_dest    per-input destination index, slice i = input i
//   in_data    per-input payload, slice i = input i
//   out_valid  per-output FIFO non-empty
//   out_ready  per-output downstream pop request
//   out_src    per-output source index of the head entry
//   out_data   per-output payload of the head entry
//   stat_count per-output 16-bit pop counter (SWITCH_STATS_EN only)
module switch_nport #(
    parameter  int NPORTS = 4,
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 4,
    localparam int DEST_W = $clog2(NPORTS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NPORTS-1:0]          in_valid,
    output logic [NPORTS-1:0]          in_ready,
    input  logic [NPORTS*DEST_W-1:0]   in_dest,
    input  logic [NPORTS*DATA_W-1:0]   in_data,
    output logic [NPORTS-1:0]          out_valid,
    input  logic [NPORTS-1:0]          out_ready,
    output logic [NPORTS*DEST_W-1:0]   out_src,
    output logic [NPORTS*DATA_W-1:0]   out_data
`ifdef SWITCH_STATS_EN
    ,
    output logic [NPORTS*16-1:0]       stat_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = DEST_W + DATA_W;

    typedef logic [DEST_W-1:0] idx_t;
    typedef logic [PW-1:0]     ptr_t;
    typedef logic [EW-1:0]     entry_t;

    idx_t              dest_s [NPORTS];
    logic [DATA_W-1:0] data_s [NPORTS];
    logic              oor    [NPORTS];

    entry_t mem_q    [NPORTS][DEPTH];
    ptr_t   wr_ptr_q [NPORTS];
    ptr_t   wr_ptr_d [NPORTS];
    ptr_t   rd_ptr_q [NPORTS];
    ptr_t   rd_ptr_d [NPORTS];
    idx_t   rr_ptr_q [NPORTS];
    idx_t   rr_ptr_d [NPORTS];

    logic [NPORTS-1:0] empty;
    logic [NPORTS-1:0] full;
    logic [NPORTS-1:0] pop;
    logic [NPORTS-1:0] gnt_vld;
    idx_t              gnt_idx [NPORTS];

    // Index that is k steps after base, wrapping modulo NPORTS.
    function automatic idx_t rr_plus(input idx_t base, input int unsigned k);
        int unsigned s;
        s = 32'(base) + k;
        return idx_t'(s % NPORTS);
    endfunction

    for (genvar i = 0; i < NPORTS; i++) begin : g_in
        assign dest_s[i] = in_dest[i*DEST_W +: DEST_W];
        assign data_s[i] = in_data[i*DATA_W +: DATA_W];
        // Destinations beyond the last port can only occur when NPORTS is
        // not a power of two. Such packets are accepted and discarded so
        // that the sender does not stall forever.
        if ((1 << DEST_W) != NPORTS) begin : g_oor
            assign oor[i] = dest_s[i] >= idx_t'(NPORTS);
        end else begin : g_pow2
            assign oor[i] = 1'b0;
        end
    end

    // FIFO status: the extra pointer MSB distinguishes full from empty.
    always_comb begin
        empty = '0;
        full  = '0;
        pop   = '0;
        for (int unsigned o = 0; o < NPORTS; o++) begin
            empty[o] = (wr_ptr_q[o] == rd_ptr_q[o]);
            full[o]  = ((wr_ptr_q[o] ^ rd_ptr_q[o]) == {1'b1, {AW{1'b0}}});
            pop[o]   = !empty[o] && out_ready[o];
        end
    end

    // Round-robin arbiters. A full FIFO never grants, even when it is being
    // popped in the same cycle.
    always_comb begin
        logic found;
        idx_t pick;
        gnt_vld = '0;
        for (int unsigned o = 0; o < NPORTS; o++) begin
            found = 1'b0;
            pick  = '0;
            if (reset && !full[o]) begin
                for (int unsigned k = 1; k <= NPORTS; k++) begin
                    if (!found && in_valid[rr_plus(rr_ptr_q[o], k)] &&
                        dest_s[rr_plus(rr_ptr_q[o], k)] == idx_t'(o)) begin
                        found = 1'b1;
                        pick  = rr_plus(rr_ptr_q[o], k);
                    end
                end
            end
            gnt_vld[o] = found;
            gnt_idx[o] = pick;
        end
    end

    always_comb begin
        in_ready = '0;
        for (int unsigned i = 0; i < NPORTS; i++) begin
            in_ready[i] = reset && in_valid[i] && oor[i];
        end
        for (int unsigned o = 0; o < NPORTS; o++) begin
            if (gnt_vld[o]) begin
                in_ready[gnt_idx[o]] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int unsigned o = 0; o < NPORTS; o++) begin
            wr_ptr_d[o] = gnt_vld[o] ? wr_ptr_q[o] + ptr_t'(1) : wr_ptr_q[o];
            rd_ptr_d[o] = pop[o]     ? rd_ptr_q[o] + ptr_t'(1) : rd_ptr_q[o];
            rr_ptr_d[o] = gnt_vld[o] ? gnt_idx[o]              : rr_ptr_q[o];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned o = 0; o < NPORTS; o++) begin
                wr_ptr_q[o] <= '0;
                rd_ptr_q[o] <= '0;
                rr_ptr_q[o] <= idx_t'(NPORTS - 1);
                for (int unsigned d = 0; d < DEPTH; d++) begin
                    mem_q[o][d] <= '0;
                end
            end
        end else begin
            for (int unsigned o = 0; o < NPORTS; o++) begin
                wr_ptr_q[o] <= wr_ptr_d[o];
                rd_ptr_q[o] <= rd_ptr_d[o];
                rr_ptr_q[o] <= rr_ptr_d[o];
                if (gnt_vld[o]) begin
                    mem_q[o][wr_ptr_q[o][AW-1:0]] <= {gnt_idx[o], data_s[gnt_idx[o]]};
                end
            end
        end
    end

    always_comb begin
        out_valid = '0;
        out_src   = '0;
        out_data  = '0;
        for (int unsigned o = 0; o < NPORTS; o++) begin
            out_valid[o] = !empty[o];
            {out_src[o*DEST_W +: DEST_W], out_data[o*DATA_W +: DATA_W]} =
                mem_q[o][rd_ptr_q[o][AW-1:0]];
        end
    end

`ifdef SWITCH_STATS_EN
    logic [15:0] stat_q [NPORTS];
    logic [15:0] stat_d [NPORTS];

    always_comb begin
        stat_count = '0;
        for (int unsigned o = 0; o < NPORTS; o++) begin
            stat_d[o] = (pop[o] && stat_q[o] != 16'hFFFF) ? stat_q[o] + 16'd1 : stat_q[o];
            stat_count[o*16 +: 16] = stat_q[o];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned o = 0; o < NPORTS; o++) begin
                stat_q[o] <= '0;
            end
        end else begin
            for (int unsigned o = 0; o < NPORTS; o++) begin
                stat_q[o] <= stat_d[o];
            end
        end
    end
`endif

endmodule

// File: tb/tb_switch_nport.sv
// Bench for switch_nport at NPORTS=4, DATA_W=8, DEPTH=4.
// Per-output queues hold the packets expected at each output.
module tb_switch_nport;

    localparam int NP = 4;
    localparam int DW = 8;
    localparam int DP = 4;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  in_valid  = '0;
    logic [3:0]  in_ready;
    logic [7:0]  in_dest   = '0;
    logic [31:0] in_data   = '0;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready = '1;
    logic [7:0]  out_src;
    logic [31:0] out_data;
`ifdef SWITCH_STATS_EN
    logic [63:0] stat_count;
    int          exp_stat [NP];
`endif

    int checks = 0;
    int errors = 0;

    logic [9:0] sb [NP][$];

    always #5 clk = ~clk;

    switch_nport #(.NPORTS(NP), .DATA_W(DW), .DEPTH(DP)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dest   (in_dest),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_src   (out_src),
        .out_data  (out_data)
`ifdef SWITCH_STATS_EN
        ,
        .stat_count(stat_count)
`endif
    );

    typedef struct {
        logic [3:0]  v;
        logic [7:0]  dest;
        logic [31:0] data;
        logic [3:0]  ordy;
        logic [3:0]  rdy;
    } vec_t;

    localparam int NV = 15;
    vec_t tbl [NV];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic check_outputs(input string nm);
        for (int unsigned o = 0; o < NP; o++) begin
            chk($sformatf("%s out_valid[%0d]", nm, o), 64'(out_valid[o]), 64'(sb[o].size() != 0));
            if (sb[o].size() != 0) begin
                chk($sformatf("%s head[%0d]", nm, o),
                    64'({out_src[o*2 +: 2], out_data[o*8 +: 8]}), 64'(sb[o][0]));
            end
        end
    endtask

    task automatic cycle(input logic [3:0] v, input logic [7:0] d, input logic [31:0] dat,
                         input logic [3:0] ordy, input logic [3:0] rdy, input string nm);
        @(negedge clk);
        in_valid  = v;
        in_dest   = d;
        in_data   = dat;
        out_ready = ordy;
        #1;
        check_outputs(nm);
        chk({nm, " in_ready"}, 64'(in_ready), 64'(rdy));
        for (int unsigned o = 0; o < NP; o++) begin
            if (sb[o].size() != 0 && ordy[o]) begin
                void'(sb[o].pop_front());
`ifdef SWITCH_STATS_EN
                exp_stat[o]++;
`endif
            end
        end
        for (int unsigned i = 0; i < NP; i++) begin
            if (rdy[i] && v[i]) sb[d[i*2 +: 2]].push_back({2'(i), dat[i*8 +: 8]});
        end
    endtask

    task automatic reset_check(input string nm);
        @(negedge clk);
        reset     = 1'b0;
        in_valid  = 4'hF;
        in_dest   = 8'h00;
        out_ready = 4'hF;
        #1;
        chk({nm, " out_valid"}, 64'(out_valid), 64'(0));
        chk({nm, " in_ready"},  64'(in_ready),  64'(0));
        chk({nm, " out_src"},   64'(out_src),   64'(0));
        chk({nm, " out_data"},  64'(out_data),  64'(0));
`ifdef SWITCH_STATS_EN
        chk({nm, " stat_count"}, stat_count, 64'(0));
        for (int unsigned o = 0; o < NP; o++) exp_stat[o] = 0;
`endif
        for (int unsigned o = 0; o < NP; o++) sb[o].delete();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = '0;
    endtask

    initial begin
        // single packet: input 2 -> output 1
        tbl[0]  = '{4'b0100, 8'h10, 32'h00A5_0000, 4'hF, 4'b0100};
        tbl[1]  = '{4'b0000, 8'h00, 32'h0,         4'hF, 4'b0000};
        tbl[2]  = '{4'b0000, 8'h00, 32'h0,         4'hF, 4'b0000};
        // contention: all inputs -> output 3, grants rotate 0,1,2,3
        tbl[3]  = '{4'b1111, 8'hFF, 32'h4433_2211, 4'hF, 4'b0001};
        tbl[4]  = '{4'b1111, 8'hFF, 32'h4433_2211, 4'hF, 4'b0010};
        tbl[5]  = '{4'b1111, 8'hFF, 32'h4433_2211, 4'hF, 4'b0100};
        tbl[6]  = '{4'b1111, 8'hFF, 32'h4433_2211, 4'hF, 4'b1000};
        tbl[7]  = '{4'b0000, 8'h00, 32'h0,         4'hF, 4'b0000};
        tbl[8]  = '{4'b0000, 8'h00, 32'h0,         4'hF, 4'b0000};
        // distinct destinations: i -> (i+1)%4, all accepted together
        tbl[9]  = '{4'b1111, 8'h39, 32'hD4C3_B2A1, 4'hF, 4'b1111};
        tbl[10] = '{4'b0000, 8'h00, 32'h0,         4'hF, 4'b0000};
        // inputs 1 and 3 -> output 0 with rr_ptr[0]=3
        tbl[11] = '{4'b1010, 8'h00, 32'h9900_8800, 4'hF, 4'b0010};
        tbl[12] = '{4'b1010, 8'h00, 32'h9900_8800, 4'hF, 4'b1000};
        tbl[13] = '{4'b0000, 8'h00, 32'h0,         4'hF, 4'b0000};
        tbl[14] = '{4'b0000, 8'h00, 32'h0,         4'hF, 4'b0000};

        reset_check("reset");

        for (int unsigned n = 0; n < NV; n++) begin
            cycle(tbl[n].v, tbl[n].dest, tbl[n].data, tbl[n].ordy, tbl[n].rdy,
                  $sformatf("vec%0d", n));
        end

        // backpressure: input 1 streams 6 packets to a stalled output 0
        for (int unsigned k = 0; k < 4; k++)
            cycle(4'b0010, 8'h00, {16'h0, 8'(8'h50 + k), 8'h0}, 4'b1110, 4'b0010, "bp_fill");
        for (int unsigned k = 0; k < 3; k++)
            cycle(4'b0010, 8'h00, 32'h0000_5400, 4'b1110, 4'b0000, "bp_full");
        cycle(4'b0010, 8'h00, 32'h0000_5400, 4'hF, 4'b0000, "bp_popfull");
        cycle(4'b0010, 8'h00, 32'h0000_5400, 4'hF, 4'b0010, "bp_pkt5");
        cycle(4'b0010, 8'h00, 32'h0000_5500, 4'hF, 4'b0010, "bp_pkt6");
        for (int unsigned k = 0; k < 4; k++)
            cycle(4'b0000, 8'h00, 32'h0, 4'hF, 4'b0000, "bp_drain");

        // full FIFO 0 with a pop in the same cycle: input 2 must wait one cycle
        for (int unsigned k = 0; k < 4; k++)
            cycle(4'b0100, 8'h00, {8'h0, 8'(8'h70 + k), 16'h0}, 4'b1110, 4'b0100, "fp_fill");
        cycle(4'b0100, 8'h00, 32'h0074_0000, 4'hF, 4'b0000, "fp_nogrant");
        cycle(4'b0100, 8'h00, 32'h0074_0000, 4'hF, 4'b0100, "fp_grant");
        for (int unsigned k = 0; k < 5; k++)
            cycle(4'b0000, 8'h00, 32'h0, 4'hF, 4'b0000, "fp_drain");

        // reset with three packets queued in FIFO 2
        for (int unsigned k = 0; k < 3; k++)
            cycle(4'b0001, 8'h02, {24'h0, 8'(8'h61 + k)}, 4'b1011, 4'b0001, "rs_fill");
        reset_check("midreset");
        cycle(4'b0000, 8'h00, 32'h0, 4'hF, 4'b0000, "rs_idle");
        cycle(4'b0000, 8'h00, 32'h0, 4'hF, 4'b0000, "rs_idle");
        // priority restarts at input 0 after reset
        cycle(4'b1001, 8'h82, 32'hEE00_00DD, 4'hF, 4'b0001, "rs_prio0");
        cycle(4'b1000, 8'h82, 32'hEE00_00DD, 4'hF, 4'b1000, "rs_prio3");
        cycle(4'b0000, 8'h00, 32'h0, 4'hF, 4'b0000, "rs_tail");
        cycle(4'b0000, 8'h00, 32'h0, 4'hF, 4'b0000, "rs_tail");

`ifdef SWITCH_STATS_EN
        for (int unsigned o = 0; o < NP; o++)
            chk($sformatf("stat_count[%0d]", o), 64'(stat_count[o*16 +: 16]), 64'(exp_stat[o]));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/switch_nport.md
# switch_nport

Parametrised N-port packet switch; successor to the fixed four-port switch in the same environment. Each input port presents single-word packets tagged with a destination port index. Per-output round-robin arbiters route each packet into a per-output FIFO, which drains over a valid/ready output stream. The block sits between the per-port interface agents and the downstream port logic, and is exercised by the same per-port monitors.

## Interface

- `NPORTS`, 4: number of input and output ports, 2..16.
- `DATA_W`, 8: payload width in bits.
- `DEPTH`, 4: entries per output FIFO; power of two, at least 2.
- `DEST_W`, derived localparam: `$clog2(NPORTS)`; width of destination and source indices.

- `clk`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  NPORTS  per-input packet valid.
- `in_ready`  out  NPORTS  per-input accept; a packet is accepted on `in_valid[i] && in_ready[i]`.
- `in_dest`  in  NPORTS*DEST_W  destination port index; slice i belongs to input i.
- `in_data`  in  NPORTS*DATA_W  payload; slice i belongs to input i.
- `out_valid`  out  NPORTS  FIFO o is non-empty.
- `out_ready`  in  NPORTS  downstream accepts the head of FIFO o.
- `out_src`  out  NPORTS*DEST_W  source input index of the head packet.
- `out_data`  out  NPORTS*DATA_W  payload of the head packet.
- `stat_count`  out  NPORTS*16  per-output delivered-packet counter. Present only with `SWITCH_STATS_EN`.

## Operation

- **Arbiter per output o:**
  - Candidates are inputs i with `in_valid[i]` and `in_dest[i]==o`.
  - If FIFO o is not full, exactly one candidate is granted. Search starts at `rr_ptr[o]+1` and wraps modulo NPORTS.
  - On a grant, `rr_ptr[o]` takes the granted index.
- **Input handshake:**
  - `in_ready[i]` is 1 only when input i is granted.
  - `in_ready` may depend combinationally on `in_valid` and `in_dest`. The requester must hold `in_valid`, `in_dest` and `in_data` stable until accepted.
- **Write:** an accepted packet is written to FIFO o as the entry {src=i, data}.
- **Out-of-range destination** (`in_dest >= NPORTS`, non-power-of-two NPORTS only): `in_ready[i]`=1 and the packet is dropped. This prevents a stall.
- **Output:** `out_valid[o]` = FIFO o non-empty. `out_src` and `out_data` show the head entry. The head is popped on `out_valid[o] && out_ready[o]`.
- **Full FIFO:**
  - No grant is given, even if a pop occurs in the same cycle (no write-through-on-pop).
  - Requesters simply wait; nothing is dropped.
- **Empty FIFO with `out_ready` high:** no pop; state unchanged.
- **Ordering:** FIFO order per output. Packets from one input to one output are never reordered.
- **FIFO pointers:** `$clog2(DEPTH)+1` bits; wrap modulo 2*DEPTH. Full when the MSBs differ and the LSBs are equal.

## Timing

- **Reset values** (reset low, asynchronous):
  - Outputs: `out_valid`=0, `in_ready`=0, `out_src`=0, `out_data`=0, `stat_count`=0.
  - Internal state: FIFOs empty, storage cleared, `rr_ptr[o]`=NPORTS-1, so input 0 has first priority.
- **Reset mid-operation:** all FIFO contents are discarded immediately. No handshake completes in a cycle where reset is low.
- **Latency:** accept at edge N gives `out_valid[o]`=1 after edge N, i.e. one cycle. There is no combinational input-to-output path.
- **Throughput:** per output, one write and one read per cycle; sustained rate is 1 packet/cycle when `out_ready` is held high.
- **Independence:** different outputs arbitrate independently. Up to NPORTS packets can be accepted per cycle when destinations are distinct.

## Configuration

- **`SWITCH_STATS_EN` defined:**
  - `stat_count` port is present.
  - Slice o increments by 1 on each pop of FIFO o.
  - It saturates at 16'hFFFF and clears only on reset.
- **`SWITCH_STATS_EN` undefined:** port and counters are absent. All other behaviour is identical.

## Test plan

- **Single packet, NPORTS=4:**
  - Stimulus: reset, then input 2 sends dest=1, data=8'hA5, with `out_ready` all high.
  - Required: `in_ready[2]`=1 in the same cycle; next cycle `out_valid[1]`=1, `out_src[1]`=2, `out_data[1]`=A5; no other `out_valid`.
- **Contention:**
  - Stimulus: inputs 0..3 all hold dest=3 for 4 cycles, with distinct data.
  - Required: grants in order 0,1,2,3. Output 3 delivers 4 packets with src 0,1,2,3 on consecutive cycles.
- **Backpressure/full, DEPTH=4:**
  - Stimulus: `out_ready[0]`=0; input 1 streams 6 packets to dest 0.
  - Required: exactly 4 accepted and `in_ready[1]` low thereafter. After raising `out_ready`, all 6 are delivered in order.
- **Full with simultaneous pop:**
  - Stimulus: FIFO 0 full, `out_ready[0]`=1, input 2 valid to dest 0.
  - Required: no grant that cycle; grant the following cycle.
- **Reset mid-stream:**
  - Stimulus: 3 packets queued in FIFO 2, then assert reset for 1 cycle.
  - Required: `out_valid[2]`=0 immediately; no stale packet appears after release.
- **Stats (with `SWITCH_STATS_EN`):**
  - Stimulus: deliver 5 packets via output 1.
  - Required: `stat_count[1]`=5 and all other slices 0.
